// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - fetch-stage control, imem and IF/ID bundle
interface instruction_fetch_unit_if #(
  parameter int IMEM_ADDR_W = 10
);
  logic                   Stall;
  logic                   Redirect;
  logic [31:0]            RedirectPC;
  logic [IMEM_ADDR_W-1:0] IMemAddr;
  logic [31:0]            IMemData;
  logic [31:0]            PC_IF;
  logic [31:0]            Instruction_ID;
  logic [31:0]            PCPlus4_ID;
  logic [5:0]             InstCode;
  logic [5:0]             FunctCode;
  logic [4:0]             RegImm;
  logic [31:0]            NopCheck;
  logic                   ValidID;
  logic [31:0]            FetchCount;
  logic [15:0]            FlushCount;

  modport master (
    input  Stall, Redirect, RedirectPC, IMemData,
    output IMemAddr, PC_IF, Instruction_ID, PCPlus4_ID, InstCode, FunctCode,
           RegImm, NopCheck, ValidID, FetchCount, FlushCount
  );

  modport slave (
    output Stall, Redirect, RedirectPC, IMemData,
    input  IMemAddr, PC_IF, Instruction_ID, PCPlus4_ID, InstCode, FunctCode,
           RegImm, NopCheck, ValidID, FetchCount, FlushCount
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC, imem addressing and IF/ID register
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_ADDR_W = 10
) (
  input logic                    Clk,
  input logic                    Rst,
  instruction_fetch_unit_if.master bus
);
  logic [31:0] pc;
  logic [31:0] inst_id;
  logic [31:0] pc_plus4_id;
  logic        valid_id;
  logic [31:0] fetch_count;
  logic [15:0] flush_count;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc + 32'd4;

  // Redirect outranks stall so a taken branch is never lost behind a hazard hold.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      pc          <= {RESET_PC[31:2], 2'b00};
      inst_id     <= 32'd0;
      pc_plus4_id <= 32'd0;
      valid_id    <= 1'b0;
      fetch_count <= 32'd0;
      flush_count <= 16'd0;
    end else if (bus.Redirect) begin
      pc          <= {bus.RedirectPC[31:2], 2'b00};
      inst_id     <= 32'd0;
      pc_plus4_id <= 32'd0;
      valid_id    <= 1'b0;
      if (flush_count != 16'hFFFF) begin
        flush_count <= flush_count + 16'd1;
      end
    end else if (!bus.Stall) begin
      pc          <= pc_plus4;
      inst_id     <= bus.IMemData;
      pc_plus4_id <= pc_plus4;
      valid_id    <= 1'b1;
      fetch_count <= fetch_count + 32'd1;
    end
  end

  assign bus.IMemAddr       = pc[IMEM_ADDR_W+1:2];
  assign bus.PC_IF          = pc;
  assign bus.Instruction_ID = inst_id;
  assign bus.PCPlus4_ID     = pc_plus4_id;
  assign bus.ValidID        = valid_id;
  assign bus.FetchCount     = fetch_count;
  assign bus.FlushCount     = flush_count;

  // A flushed slot is all zeros, so every decode slice reads as a NOP.
  assign bus.InstCode  = inst_id[31:26];
  assign bus.FunctCode = inst_id[5:0];
  assign bus.RegImm    = inst_id[20:16];
  assign bus.NopCheck  = inst_id;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed checks for instruction_fetch_unit
module tb_instruction_fetch_unit;
  logic Clk;
  logic Rst;
  int   checks;
  int   failures;

  instruction_fetch_unit_if #(.IMEM_ADDR_W(10)) bus ();

  instruction_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_ADDR_W(10)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  // Instruction memory: word i holds 0x2000_0000 + i.
  assign bus.IMemData = 32'h2000_0000 + 32'(bus.IMemAddr);

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    Rst            = 1'b0;
    bus.Stall      = 1'b0;
    bus.Redirect   = 1'b0;
    bus.RedirectPC = 32'd0;
    @(negedge Clk);
    step();
    check("rst_pc",    bus.PC_IF, 32'd0);
    check("rst_inst",  bus.Instruction_ID, 32'd0);
    check("rst_pc4",   bus.PCPlus4_ID, 32'd0);
    check("rst_valid", 32'(bus.ValidID), 32'd0);
    check("rst_fetch", bus.FetchCount, 32'd0);
    check("rst_flush", 32'(bus.FlushCount), 32'd0);
    check("rst_addr",  32'(bus.IMemAddr), 32'd0);

    Rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("run_inst",  bus.Instruction_ID, 32'h2000_0000 + 32'(i));
      check("run_pc4",   bus.PCPlus4_ID, 32'(4 * (i + 1)));
      check("run_valid", 32'(bus.ValidID), 32'd1);
    end

    bus.Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_inst",  bus.Instruction_ID, 32'h2000_0002);
      check("stall_pc",    bus.PC_IF, 32'd12);
      check("stall_addr",  32'(bus.IMemAddr), 32'd3);
      check("stall_fetch", bus.FetchCount, 32'd3);
    end
    bus.Stall = 1'b0;
    step();
    check("resume_inst",  bus.Instruction_ID, 32'h2000_0003);
    check("resume_pc4",   bus.PCPlus4_ID, 32'd16);
    check("resume_pc",    bus.PC_IF, 32'd16);
    check("resume_fetch", bus.FetchCount, 32'd4);

    bus.Redirect   = 1'b1;
    bus.RedirectPC = 32'h40;
    step();
    bus.Redirect = 1'b0;
    check("redir_pc",    bus.PC_IF, 32'h40);
    check("redir_inst",  bus.Instruction_ID, 32'd0);
    check("redir_valid", 32'(bus.ValidID), 32'd0);
    check("redir_nop",   bus.NopCheck, 32'd0);
    check("redir_op",    32'(bus.InstCode), 32'd0);
    check("redir_flush", 32'(bus.FlushCount), 32'd1);
    check("redir_fetch", bus.FetchCount, 32'd4);
    step();
    check("target_inst",  bus.Instruction_ID, 32'h2000_0010);
    check("target_pc4",   bus.PCPlus4_ID, 32'h44);
    check("target_op",    32'(bus.InstCode), 32'd8);
    check("target_funct", 32'(bus.FunctCode), 32'h10);
    check("target_rt",    32'(bus.RegImm), 32'd0);
    check("target_fetch", bus.FetchCount, 32'd5);

    bus.Redirect   = 1'b1;
    bus.Stall      = 1'b1;
    bus.RedirectPC = 32'h23;
    step();
    bus.Redirect = 1'b0;
    bus.Stall    = 1'b0;
    check("rs_pc",    bus.PC_IF, 32'h20);
    check("rs_addr",  32'(bus.IMemAddr), 32'd8);
    check("rs_inst",  bus.Instruction_ID, 32'd0);
    check("rs_valid", 32'(bus.ValidID), 32'd0);
    check("rs_flush", 32'(bus.FlushCount), 32'd2);
    step();
    check("rs_next_inst", bus.Instruction_ID, 32'h2000_0008);
    check("rs_next_pc",   bus.PC_IF, 32'h24);

    force dut.flush_count = 16'hFFFE;
    #1;
    release dut.flush_count;
    bus.Redirect   = 1'b1;
    bus.RedirectPC = 32'h100;
    step();
    check("sat_first", 32'(bus.FlushCount), 32'hFFFF);
    step();
    step();
    bus.Redirect = 1'b0;
    check("sat_hold",  32'(bus.FlushCount), 32'hFFFF);
    check("sat_pc",    bus.PC_IF, 32'h100);
    check("sat_valid", 32'(bus.ValidID), 32'd0);

    force dut.pc = 32'hFFFF_FFFC;
    #1;
    release dut.pc;
    check("wrap_addr", 32'(bus.IMemAddr), 32'h3FF);
    step();
    check("wrap_pc",   bus.PC_IF, 32'd0);
    check("wrap_pc4",  bus.PCPlus4_ID, 32'd0);
    check("wrap_inst", bus.Instruction_ID, 32'h2000_03FF);

    Rst            = 1'b0;
    bus.Redirect   = 1'b1;
    bus.Stall      = 1'b1;
    bus.RedirectPC = 32'h80;
    step();
    check("mrst_pc",    bus.PC_IF, 32'd0);
    check("mrst_inst",  bus.Instruction_ID, 32'd0);
    check("mrst_pc4",   bus.PCPlus4_ID, 32'd0);
    check("mrst_valid", 32'(bus.ValidID), 32'd0);
    check("mrst_fetch", bus.FetchCount, 32'd0);
    check("mrst_flush", 32'(bus.FlushCount), 32'd0);
    Rst          = 1'b1;
    bus.Redirect = 1'b0;
    bus.Stall    = 1'b0;
    step();
    check("post_inst",  bus.Instruction_ID, 32'h2000_0000);
    check("post_fetch", bus.FetchCount, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
